// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s), fixed baud.
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   S_IDLE   | line high, ready for a word
//   S_START  | start bit (low) for one bit period
//   S_DATA   | data bits, LSB first, one bit period each
//   S_PARITY | parity bit (only when PARITY != 0)
//   S_STOP   | stop bit(s), line high
module uart_tx #(
    parameter int CLOCK_RATE = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 busy,
    output logic                 tx
);

    localparam int CPB = CLOCK_RATE / BAUD_RATE;
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int IW  = $clog2(DATA_BITS);
    localparam bit PAR_EN = (PARITY != 0);
    localparam bit PAR_ODD = (PARITY == 1);
`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (CPB < 2) begin : g_bad_cpb
        $error("uart_tx: CLOCK_RATE / BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
        $error("uart_tx: DATA_BITS must be in 5..9");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CW-1:0]        baud_cnt;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 tx_q;
    logic                 tx_next;
    logic                 bit_done;
    logic                 accept;

    assign bit_done = (baud_cnt == CW'(CPB - 1));
    assign accept   = tx_valid && (state == S_IDLE);
    assign tx_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);
    assign tx       = tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        tx_next    = 1'b1;
        case (state)
            S_IDLE: begin
                if (tx_valid) state_next = S_START;
            end
            S_START: begin
                tx_next = 1'b0;
                if (bit_done) state_next = S_DATA;
            end
            S_DATA: begin
                tx_next = shift_q[0];
                if (bit_done && bit_idx == IW'(DATA_BITS - 1))
                    state_next = PAR_EN ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                tx_next = par_q;
                if (bit_done) state_next = S_STOP;
            end
            S_STOP: begin
                if (bit_done && bit_idx == IW'(STOP_BITS - 1)) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // tx is registered from the state decode, so the line lags state by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            tx_q <= tx_next;
            if (accept) begin
                shift_q  <= tx_data;
                par_q    <= (^tx_data) ^ PAR_ODD;
                baud_cnt <= '0;
                bit_idx  <= '0;
            end else if (state != S_IDLE) begin
                if (bit_done) begin
                    baud_cnt <= '0;
                    if (state == S_DATA) shift_q <= shift_q >> 1;
                    bit_idx <= (state_next != state) ? '0 : bit_idx + IW'(1);
                end else begin
                    baud_cnt <= baud_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no/odd/even parity) checked cycle by cycle
// against frames built from the bit-level frame format.
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_TWO_STOP_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] valid_s;
    logic [2:0] tx_s;
    logic [2:0] ready_s;
    logic [2:0] busy_s;
    logic [7:0] data_s [3];

    int ncmp = 0;
    int nerr = 0;
    int cyc = 0;
    bit exp_bits [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.CLOCK_RATE(1000000), .BAUD_RATE(250000), .DATA_BITS(8), .PARITY(0)) u_none (
        .clk(clk), .rst_n(rst_n), .tx_data(data_s[0]), .tx_valid(valid_s[0]),
        .tx_ready(ready_s[0]), .busy(busy_s[0]), .tx(tx_s[0]));
    uart_tx #(.CLOCK_RATE(1000000), .BAUD_RATE(250000), .DATA_BITS(8), .PARITY(1)) u_odd (
        .clk(clk), .rst_n(rst_n), .tx_data(data_s[1]), .tx_valid(valid_s[1]),
        .tx_ready(ready_s[1]), .busy(busy_s[1]), .tx(tx_s[1]));
    uart_tx #(.CLOCK_RATE(1000000), .BAUD_RATE(250000), .DATA_BITS(8), .PARITY(2)) u_even (
        .clk(clk), .rst_n(rst_n), .tx_data(data_s[2]), .tx_valid(valid_s[2]),
        .tx_ready(ready_s[2]), .busy(busy_s[2]), .tx(tx_s[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // channel 0 = no parity, 1 = odd, 2 = even
    task automatic build(input logic [7:0] d, input int ch, output int n);
        int ones;
        int pos;
        ones = $countones(d);
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[1 + i] = d[i];
        pos = 9;
        if (ch == 1) begin exp_bits[pos] = (ones % 2 == 0); pos++; end
        if (ch == 2) begin exp_bits[pos] = (ones % 2 == 1); pos++; end
        for (int i = 0; i < S; i++) begin exp_bits[pos] = 1'b1; pos++; end
        n = pos;
    endtask

    task automatic accept(input int ch, input logic [7:0] d, input bit hold, output int k);
        int w;
        w = 0;
        @(negedge clk);
        while (!ready_s[ch] && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", ready_s[ch], 1);
        valid_s[ch] = 1'b1;
        data_s[ch]  = d;
        @(posedge clk);
        #1;
        k = cyc;
        chk("accept_tx_still_high", tx_s[ch], 1);
        chk("accept_ready_low", ready_s[ch], 0);
        if (!hold) begin
            valid_s[ch] = 1'b0;
            data_s[ch]  = 8'($urandom);
        end
    endtask

    // poke pulses tx_valid mid-frame; it must be ignored
    task automatic check_frame(input int ch, input logic [7:0] d, input bit poke);
        int n;
        build(d, ch, n);
        for (int j = 1; j <= n * CPB; j++) begin
            @(posedge clk);
            #1;
            if (poke && j == 2 * CPB + 1) valid_s[ch] = 1'b0;
            chk("tx_bit", tx_s[ch], exp_bits[(j - 1) / CPB]);
            chk("ready", ready_s[ch], (j == n * CPB));
            chk("busy", busy_s[ch], (j != n * CPB));
            if (poke && j == 2 * CPB) begin
                valid_s[ch] = 1'b1;
                data_s[ch]  = 8'($urandom);
            end
        end
    endtask

    task automatic send(input int ch, input logic [7:0] d, input bit poke);
        int k;
        accept(ch, d, 1'b0, k);
        check_frame(ch, d, poke);
        @(posedge clk);
        #1;
        chk("post_idle_tx", tx_s[ch], 1);
        chk("post_idle_ready", ready_s[ch], 1);
    endtask

    initial begin
        int k1;
        int k2;
        int n;
        valid_s = '0;
        for (int i = 0; i < 3; i++) data_s[i] = 8'h00;

        #2 rst_n = 1'b0;
        valid_s = 3'b111;
        data_s[0] = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx_s, 3'b111);
        chk("rst_ready", ready_s, 3'b111);
        chk("rst_busy", busy_s, 3'b000);
        valid_s = '0;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_tx", tx_s, 3'b111);
        chk("post_rst_ready", ready_s, 3'b111);

        send(0, 8'hA5, 1'b0);
        send(1, 8'h07, 1'b0);
        send(2, 8'h07, 1'b0);
        send(0, 8'hFF, 1'b0);

        accept(0, 8'h01, 1'b1, k1);
        data_s[0] = 8'h80;
        check_frame(0, 8'h01, 1'b0);
        @(posedge clk);
        #1;
        k2 = cyc;
        build(8'h01, 0, n);
        chk("b2b_spacing", k2 - k1, n * CPB + 1);
        chk("b2b_idle_gap_tx", tx_s[0], 1);
        chk("b2b_ready_low", ready_s[0], 0);
        valid_s[0] = 1'b0;
        check_frame(0, 8'h80, 1'b0);

        accept(0, 8'($urandom), 1'b0, k1);
        repeat (4 * CPB + 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", tx_s[0], 1);
        chk("midrst_ready", ready_s[0], 1);
        chk("midrst_busy", busy_s[0], 0);
        @(negedge clk) rst_n = 1'b1;
        send(0, 8'h3C, 1'b0);

        for (int i = 0; i < 5; i++)
            for (int ch = 0; ch < 3; ch++)
                send(ch, 8'($urandom), (i % 2) == 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter; the transmit counterpart of the board's `uart_rx` and matched to it on frame format (start bit, LSB-first data, optional parity, stop).

- Accepts one data word per valid/ready handshake and shifts it out on `tx` at a fixed baud rate derived from the system clock.
- Sits between on-chip logic and the USB-UART bridge pin `usb_tx`.

## Interface
Parameters:
- `CLOCK_RATE`, 100000000: system clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate in bit/s.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even; any other value is an elaboration error.

Ports:
- `clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tx_data` in DATA_BITS: word to send; sampled only on the accept edge.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: block can accept a word.
- `busy` out 1: a frame is in progress.
- `tx` out 1: serial line, idle high.

## Operation
- CPB = CLOCK_RATE / BAUD_RATE (integer division, truncating); 868 at defaults.
  - CPB < 2 is an elaboration error.
  - Baud counter width is $clog2(CPB).
- P = 1 if PARITY != 0, else 0. S = 1 stop bit (2 with the macro).
- State machine:
  - IDLE → START → DATA → (PARITY if P) → STOP → IDLE.
  - IDLE: `tx`=1, `tx_ready`=1, `busy`=0. On `tx_valid && tx_ready`: latch `tx_data` into the shift register, clear the baud counter and bit index, go to START.
  - START: `tx`=0 for CPB cycles.
  - DATA: `tx` = shift register bit 0 for CPB cycles per bit, LSB first, DATA_BITS bits; shift right after each bit.
  - PARITY: `tx` = XOR of the latched data, inverted for odd parity, for CPB cycles. Odd parity makes the total number of ones in data plus parity odd; even parity makes it even.
  - STOP: `tx`=1 for S×CPB cycles, then IDLE.
- `tx_ready` = (state == IDLE); `busy` = !tx_ready. Both are registered-state decodes with no combinational path from `tx_valid`.
- `tx` is driven from a register (glitch-free).
- `tx_data` changes after the accept edge have no effect on the frame in flight.
- `tx_valid` while not ready is ignored; it is not queued.
- Reset values: `tx`=1, `tx_ready`=1, `busy`=0, state IDLE, counters 0.
- Reset mid-frame: `tx` returns high asynchronously and the frame is abandoned (a receiver sees a framing error at most). Operation resumes from IDLE after release.

## Timing
- Accept at edge k: `tx` falls after edge k+1 (latency 1 cycle).
- N = 1 + DATA_BITS + P + S bit periods per frame.
- `tx_ready` deasserts from edge k+1 and reasserts after edge k+1+N×CPB.
- Earliest next accept is that same edge, so back-to-back accepts are spaced N×CPB+1 cycles apart (one idle-high cycle between frames).
- Every bit period is exactly CPB cycles, with no cumulative drift across the frame.

## Configuration
- `UART_TX_TWO_STOP_EN`:
  - Defined: S = 2 and the stop phase lasts 2×CPB cycles high.
  - Undefined: S = 1, CPB cycles.
  - No other behaviour changes.

## Test plan
Bench uses CLOCK_RATE=1000000, BAUD_RATE=250000 (CPB=4), DATA_BITS=8.
- Reset: hold `rst_n`=0 → `tx`=1, `tx_ready`=1, `busy`=0. Pulse `tx_valid` during reset → no frame.
- PARITY=0, send 0xA5 → one cycle after accept, `tx` = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. `tx_ready` is low for 40 cycles, then high.
- Parity 0x07:
  - PARITY=2 → parity bit 1.
  - PARITY=1 → parity bit 0.
  - Frame is 11 bits (44 cycles) in both cases.
- Back-to-back: `tx_valid` held high with 0x01 then 0x80, PARITY=0 → accepts 41 cycles apart; exactly one idle-high cycle between the first stop bit and the second start bit.
- Reset mid-frame: assert `rst_n`=0 during data bit 3 → `tx`=1 and `tx_ready`=1 in the same cycle. After release, sending 0x3C produces a clean, correct frame.
- With `UART_TX_TWO_STOP_EN` defined, send 0xFF, PARITY=0 → stop high 8 cycles; accept-to-ready spacing is 44 cycles.
- Loopback (optional): at the default CLOCK_RATE, `tx` into `uart_rx` with matching parameters, sending 0x00..0xFF → `uart_rx` reports each value with no `error` pulse.
